// File: rtl/pe_os_drain.sv
// rtl/pe_os_drain.sv - output-stationary MAC processing element with drain chain
// Optional feature macro PE_ACC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module pe_os_drain #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a_in,
  input  logic                 a_vld_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic                 b_vld_in,
  input  logic                 sign_mode,
  input  logic                 clc,
  input  logic                 latch,
  input  logic                 drain_shift,
  input  logic [ACC_WIDTH-1:0] drain_in,
  input  logic                 drain_vld_in,
  output logic [WIDTH-1:0]     a_out,
  output logic                 a_vld_out,
  output logic [WIDTH-1:0]     b_out,
  output logic                 b_vld_out,
  output logic [ACC_WIDTH-1:0] drain_out,
  output logic                 drain_vld_out,
  output logic [ACC_WIDTH-1:0] acc,
  output logic [CNT_W-1:0]     mac_cnt,
  output logic                 ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int XW = ACC_WIDTH + 1;

  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic                 a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] drain_q, drain_d;
  logic                 drain_vld_q, drain_vld_d;

  logic                 fire;
  logic [PW-1:0]        prod_s, prod_u, prod;
  logic [XW-1:0]        prod_ext, acc_ext, sum;
  logic                 add_ovf;
  logic [ACC_WIDTH-1:0] acc_mac;
`ifdef PE_ACC_SAT_EN
  logic [ACC_WIDTH-1:0] sat_val;
`endif

  assign fire = a_vld_in & b_vld_in;

  // Low 2*WIDTH bits of a product of extended operands equal the true signed/unsigned product.
  assign prod_s = {{WIDTH{a_in[WIDTH-1]}}, a_in} * {{WIDTH{b_in[WIDTH-1]}}, b_in};
  assign prod_u = {{WIDTH{1'b0}}, a_in} * {{WIDTH{1'b0}}, b_in};
  assign prod   = sign_mode ? prod_s : prod_u;

  assign prod_ext = sign_mode ? {{(XW-PW){prod[PW-1]}}, prod} : {{(XW-PW){1'b0}}, prod};
  assign acc_ext  = sign_mode ? {acc_q[ACC_WIDTH-1], acc_q} : {1'b0, acc_q};
  assign sum      = acc_ext + prod_ext;
  assign add_ovf  = sign_mode ? (sum[XW-1] ^ sum[XW-2]) : sum[XW-1];

`ifdef PE_ACC_SAT_EN
  // In signed mode the extra sum bit is the true sign, selecting which rail to clamp to.
  always_comb begin
    sat_val = '1;
    if (sign_mode) begin
      sat_val = sum[XW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end
  assign acc_mac = add_ovf ? sat_val : sum[ACC_WIDTH-1:0];
`else
  assign acc_mac = sum[ACC_WIDTH-1:0];
`endif

  always_comb begin
    a_d         = a_in;
    a_vld_d     = a_vld_in;
    b_d         = b_in;
    b_vld_d     = b_vld_in;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    drain_d     = drain_q;
    drain_vld_d = drain_vld_q;

    if (clc) begin
      acc_d = fire ? prod_ext[ACC_WIDTH-1:0] : '0;
      cnt_d = fire ? CNT_W'(1) : '0;
      ovf_d = 1'b0;
    end else if (fire) begin
      acc_d = acc_mac;
      cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
      ovf_d = ovf_q | add_ovf;
    end

    // Latch captures the pre-update accumulator and takes priority over shifting.
    if (latch) begin
      drain_d     = acc_q;
      drain_vld_d = 1'b1;
    end else if (drain_shift) begin
      drain_d     = drain_in;
      drain_vld_d = drain_vld_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      a_vld_q     <= 1'b0;
      b_q         <= '0;
      b_vld_q     <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      drain_q     <= '0;
      drain_vld_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      a_vld_q     <= a_vld_d;
      b_q         <= b_d;
      b_vld_q     <= b_vld_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      drain_q     <= drain_d;
      drain_vld_q <= drain_vld_d;
    end
  end

  assign a_out         = a_q;
  assign a_vld_out     = a_vld_q;
  assign b_out         = b_q;
  assign b_vld_out     = b_vld_q;
  assign acc           = acc_q;
  assign mac_cnt       = cnt_q;
  assign ovf           = ovf_q;
  assign drain_out     = drain_q;
  assign drain_vld_out = drain_vld_q;

endmodule
